// File: rtl/ls_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ls_pkg
// Description : Shared funct3 codes and FSM state encoding for the load/store unit.
// Revision    : 1.0
// ============================================================================
package ls_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      OCIOSO   = 3'b000,
      LEITURA  = 3'b001,
      ESPERA   = 3'b010,
      ESCRITA  = 3'b011,
      RESPOSTA = 3'b100
   } estado_t;

endpackage
`default_nettype wire

// File: rtl/alinhador_dados.sv
`default_nettype none
// ============================================================================
// Module      : alinhador_dados
// Description : Lane select/extend for loads and lane merge for sub-word stores.
// Revision    : 1.0
// ============================================================================
module alinhador_dados
   import ls_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   assign byte_w = word_i[{off_i, 3'b000} +: 8];
   assign half_w = off_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      load_o = 32'h0;
      case (funct3_i)
         F3_B:    load_o = {{24{byte_w[7]}}, byte_w};
         F3_H:    load_o = {{16{half_w[15]}}, half_w};
         F3_W:    load_o = word_i;
         F3_BU:   load_o = {24'h0, byte_w};
         F3_HU:   load_o = {16'h0, half_w};
         default: load_o = 32'h0;
      endcase
   end

   // Untouched lanes keep the word just read back from memory.
   always_comb begin
      store_o = word_i;
      case (funct3_i)
         F3_B: store_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
         F3_H: begin
            if (off_i[1]) store_o[31:16] = wdata_i[15:0];
            else          store_o[15:0]  = wdata_i[15:0];
         end
         F3_W:    store_o = wdata_i;
         default: store_o = word_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/unidade_load_store.sv
`default_nettype none
// ============================================================================
// Module      : unidade_load_store
// Description : MEM-stage initiator for word-addressed data memory (loads, stores, RMW sb/sh).
// Revision    : 1.0
// ============================================================================
module unidade_load_store
   import ls_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [2:0]    req_funct3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          resp_valid,
   output logic [31:0]   resp_rdata,
   output logic          resp_err,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [31:0]   mem_rdata
);

   estado_t       estado_q;
   logic          write_q;
   logic [2:0]    funct3_q;
   logic [1:0]    off_q;
   logic [31:0]   wdata_q;
   logic          resp_valid_q, resp_err_q, mem_we_q, mem_re_q;
   logic [31:0]   resp_rdata_q, mem_wdata_q;
   logic [AW-1:0] mem_addr_q;

   logic          erro_d;
   logic [31:0]   indice_d;
   logic [31:0]   load_d, store_d;

   assign indice_d = {2'b00, req_addr[31:2]};

   always_comb begin
      erro_d = 1'b0;
      case (req_funct3)
         F3_B:    erro_d = 1'b0;
         F3_H:    erro_d = req_addr[0];
         F3_W:    erro_d = |req_addr[1:0];
         F3_BU:   erro_d = req_write;
         F3_HU:   erro_d = req_write | req_addr[0];
         default: erro_d = 1'b1;
      endcase
      if (indice_d >= 32'(DEPTH)) erro_d = 1'b1;
   end

   // Fed straight from mem_rdata so the ESPERA edge captures the finished result.
   alinhador_dados u_alinhador (
      .word_i   (mem_rdata),
      .funct3_i (funct3_q),
      .off_i    (off_q),
      .wdata_i  (wdata_q),
      .load_o   (load_d),
      .store_o  (store_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q     <= OCIOSO;
         write_q      <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         wdata_q      <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'h0;
      end else begin
         case (estado_q)
            OCIOSO: begin
               if (req_valid) begin
                  write_q  <= req_write;
                  funct3_q <= req_funct3;
                  off_q    <= req_addr[1:0];
                  wdata_q  <= req_wdata;
                  if (erro_d) begin
                     estado_q     <= RESPOSTA;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0;
                  end else if (req_write && req_funct3 == F3_W) begin
                     estado_q    <= ESCRITA;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= req_addr[AW+1:2];
                     mem_wdata_q <= req_wdata;
                  end else begin
                     estado_q   <= LEITURA;
                     mem_re_q   <= 1'b1;
                     mem_addr_q <= req_addr[AW+1:2];
                  end
               end
            end
            LEITURA: begin
               mem_re_q <= 1'b0;
               estado_q <= ESPERA;
            end
            ESPERA: begin
               if (write_q) begin
                  mem_wdata_q <= store_d;
                  mem_we_q    <= 1'b1;
                  estado_q    <= ESCRITA;
               end else begin
                  resp_rdata_q <= load_d;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  estado_q     <= RESPOSTA;
               end
            end
            ESCRITA: begin
               mem_we_q     <= 1'b0;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'h0;
               estado_q     <= RESPOSTA;
            end
            RESPOSTA: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'h0;
               estado_q     <= OCIOSO;
            end
            default: estado_q <= OCIOSO;
         endcase
      end
   end

   assign req_ready  = (estado_q == OCIOSO);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_we     = mem_we_q;
   assign mem_re     = mem_re_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_unidade_load_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_load_store
// Description : Self-checking bench with a word memory and an arithmetic reference model.
// Revision    : 1.0
// ============================================================================
module tb_unidade_load_store;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_write;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr, req_wdata;
   logic          resp_valid, resp_err;
   logic [31:0]   resp_rdata;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;
   logic          mem_we, mem_re;

   logic [31:0]   mem     [DEPTH];
   logic [31:0]   ref_mem [DEPTH];
   logic          load_mem;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   unidade_load_store #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata)
   );

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
         mem_rdata <= 32'h0;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         if (mem_re) mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: expected outcome of one request, updating ref_mem for stores.
   task automatic modelo(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd,
                         output int e_lat, output int e_re, output int e_we,
                         output logic [31:0] e_word);
      int unsigned idx, sh, v;
      logic [31:0] word, mask;
      idx = addr / 4;
      sh = (addr % 4) * 8;
      e_err = 1'b0;
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e_err = 1'b1;
      if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) e_err = 1'b1;
      if (f3 == 3'd2 && (addr % 4 != 0)) e_err = 1'b1;
      if ((f3 == 3'd4 || f3 == 3'd5) && w) e_err = 1'b1;
      if (idx >= DEPTH) e_err = 1'b1;
      e_rd = 0; e_re = 0; e_we = 0; e_word = 0;
      if (e_err) begin
         e_lat = 1;
         return;
      end
      word = ref_mem[idx];
      if (!w) begin
         e_lat = 3; e_re = 1;
         case (f3)
            3'd0, 3'd4: begin
               v = (word >> sh) % 256;
               if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
               v = (word >> sh) % 65536;
               if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = word;
         endcase
         e_rd = v;
      end else begin
         e_we = 1;
         if (f3 == 3'd2) begin
            e_lat = 2; e_word = wd;
         end else begin
            e_lat = 4; e_re = 1;
            mask = (f3 == 3'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
            e_word = (word & ~mask) | ((wd << sh) & mask);
         end
         ref_mem[idx] = e_word;
      end
   endtask

   task automatic run_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
      logic e_err; logic [31:0] e_rd, e_word, got_word, got_rd, got_addr;
      int e_lat, e_re, e_we, n, lat, re_n, we_n;
      logic got_err;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk({tag, ".ready"}, 32'(req_ready), 32'd1);
      modelo(w, f3, addr, wd, e_err, e_rd, e_lat, e_re, e_we, e_word);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = $urandom; req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 0; re_n = 0; we_n = 0; got_word = 0; got_rd = 0; got_err = 0; got_addr = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (mem_re) begin
            re_n++;
            chk({tag, ".re_addr"}, 32'(mem_addr), addr / 4);
         end
         if (mem_we) begin
            we_n++; got_word = mem_wdata;
            chk({tag, ".we_addr"}, 32'(mem_addr), addr / 4);
         end
         if (resp_valid) begin
            lat = k; got_err = resp_err; got_rd = resp_rdata; got_addr = 32'(mem_addr);
            break;
         end
      end
      chk({tag, ".latency"}, lat, e_lat);
      chk({tag, ".err"}, 32'(got_err), 32'(e_err));
      chk({tag, ".rdata"}, got_rd, e_rd);
      chk({tag, ".re_count"}, re_n, e_re);
      chk({tag, ".we_count"}, we_n, e_we);
      if (e_we != 0) chk({tag, ".wword"}, got_word, e_word);
      if (!e_err) chk({tag, ".addr_hold"}, got_addr, addr / 4);
      @(negedge clk);
      chk({tag, ".pulse"}, 32'(resp_valid), 32'd0);
      chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int acc, m_on, we_seen;
      logic [31:0] q_rd [$];
      logic [31:0] q_ra [$];
      logic [31:0] keep, wd, ad;
      logic w;
      logic [2:0] f3;

      rst_n = 1'b0; load_mem = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 0; req_wdata = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      load_mem = 1'b0;
      chk("rst.ready", 32'(req_ready), 32'd1);
      chk("rst.outs", {26'(0), resp_valid, resp_err, mem_we, mem_re, 2'b00}, 32'd0);
      chk("rst.rdata", resp_rdata, 32'd0);
      chk("rst.addr_wdata", 32'(mem_addr) | mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_req("sw08", 1'b1, 3'd2, 32'h08, 32'hDEADBEEF);
      chk("sw08.mem", mem[2], 32'hDEADBEEF);
      run_req("lb0B", 1'b0, 3'd0, 32'h0B, 32'h0);
      run_req("lbu0B", 1'b0, 3'd4, 32'h0B, 32'h0);
      run_req("lh08", 1'b0, 3'd1, 32'h08, 32'h0);
      run_req("sb09", 1'b1, 3'd0, 32'h09, 32'h00000055);
      chk("sb09.mem", mem[2], 32'hDEAD55EF);
      run_req("lw08", 1'b0, 3'd2, 32'h08, 32'h0);
      run_req("sh0E", 1'b1, 3'd1, 32'h0E, 32'h1234ABCD);
      run_req("lhu0E", 1'b0, 3'd5, 32'h0E, 32'h0);
      run_req("e_lw06", 1'b0, 3'd2, 32'h06, 32'h0);
      run_req("e_lw100", 1'b0, 3'd2, 32'h100, 32'h0);
      run_req("e_f3_011", 1'b0, 3'd3, 32'h10, 32'h0);
      run_req("e_sbu", 1'b1, 3'd4, 32'h10, 32'h0);
      run_req("e_sh_odd", 1'b1, 3'd1, 32'h11, 32'h0);

      // Reset in the middle of an sh read-modify-write.
      keep = mem[3];
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1; req_addr = 32'h0E; req_wdata = 32'hCAFE;
      @(posedge clk); #1; req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort.ready", 32'(req_ready), 32'd1);
      chk("abort.outs", {28'(0), resp_valid, resp_err, mem_we, mem_re}, 32'd0);
      chk("abort.rdata", resp_rdata, 32'd0);
      chk("abort.addr_wdata", 32'(mem_addr) | mem_wdata, 32'd0);
      rst_n = 1'b1;
      m_on = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (resp_valid || mem_we || mem_re) m_on++;
      end
      chk("abort.quiet", m_on, 0);
      chk("abort.mem", mem[3], keep);

      // req_valid held while busy: only two requests, in order.
      acc = 0; we_seen = 0;
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h00;
      for (int k = 0; k < 20; k++) begin
         if (resp_valid) q_rd.push_back(resp_rdata);
         if (mem_re) q_ra.push_back(32'(mem_addr));
         if (mem_we) we_seen++;
         if (req_valid && req_ready) begin
            acc++;
            @(posedge clk); #1;
            if (acc == 1) req_addr = 32'h04;
            else req_valid = 1'b0;
         end else begin
            @(posedge clk); #1;
            if (acc == 1) req_addr = 32'h04 + 32'(k % 3) * 4;
         end
         @(negedge clk);
      end
      chk("b2b.accepts", acc, 2);
      chk("b2b.nresp", q_rd.size(), 2);
      chk("b2b.nre", q_ra.size(), 2);
      chk("b2b.we", we_seen, 0);
      if (q_rd.size() == 2) begin
         chk("b2b.rd0", q_rd[0], ref_mem[0]);
         chk("b2b.rd1", q_rd[1], ref_mem[1]);
      end
      if (q_ra.size() == 2) begin
         chk("b2b.ra0", q_ra[0], 32'd0);
         chk("b2b.ra1", q_ra[1], 32'd1);
      end

      for (int t = 0; t < 60; t++) begin
         w  = 1'($urandom);
         f3 = 3'($urandom_range(0, 7));
         ad = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH) + $urandom_range(0, 1023)
                                            : $urandom_range(0, 4 * DEPTH - 1);
         wd = $urandom;
         run_req("rnd", w, f3, ad, wd);
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i] !== ref_mem[i]) chk("final.mem", mem[i], ref_mem[i]);
      end
      chk("final.mem_w2", mem[2], ref_mem[2]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
